// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shared-bus arbiter: master priority, round-robin CiMs, hold limit, turnaround
module bus_arbiter #(
   parameter int NUM_CIMS = 64,
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 16,
   localparam int IDX_W   = (NUM_CIMS > 1) ? $clog2(NUM_CIMS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                master_req,
   input  logic [NUM_CIMS-1:0] cim_req,
   input  logic                clr_stats,
   output logic                master_gnt,
   output logic [NUM_CIMS-1:0] cim_gnt,
   output logic [IDX_W-1:0]    grant_id,
   output logic                bus_busy,
   output logic                timeout_err,
   output logic [CNT_W-1:0]    grant_count
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic              pick_valid;
   logic              pick_master;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  next_ptr;
   logic              grant_issue;
   logic              owner_req;
   int                j;

   // Master wins outright; otherwise first requesting CiM at or after rr_ptr, wrapping.
   always_comb begin
      pick_valid  = 1'b0;
      pick_master = 1'b0;
      pick_idx    = '0;
      j           = 0;
      if (master_req) begin
         pick_valid  = 1'b1;
         pick_master = 1'b1;
      end else begin
         for (int i = 0; i < NUM_CIMS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_CIMS) j = j - NUM_CIMS;
            if (!pick_valid && cim_req[j]) begin
               pick_valid = 1'b1;
               pick_idx   = IDX_W'(j);
            end
         end
      end
   end

   assign next_ptr    = (pick_idx == IDX_W'(NUM_CIMS - 1)) ? '0 : pick_idx + 1'b1;
   assign grant_issue = (state != GRANT) && enable && pick_valid;
   assign owner_req   = master_gnt ? master_req : cim_req[grant_id];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         master_gnt  <= 1'b0;
         cim_gnt     <= '0;
         grant_id    <= '0;
         bus_busy    <= 1'b0;
         timeout_err <= 1'b0;
         grant_count <= '0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
      end else begin
         timeout_err <= 1'b0;
         if (clr_stats)
            grant_count <= '0;
         else if (grant_issue && grant_count != '1)
            grant_count <= grant_count + 1'b1;

         case (state)
            IDLE, TURNAROUND: begin
               if (grant_issue) begin
                  state    <= GRANT;
                  bus_busy <= 1'b1;
                  if (pick_master) begin
                     master_gnt <= 1'b1;
                     hold_cnt   <= '0;
                  end else begin
                     cim_gnt  <= NUM_CIMS'(1) << pick_idx;
                     grant_id <= pick_idx;
                     rr_ptr   <= next_ptr;
                     hold_cnt <= HOLD_W'(1);
                  end
               end else begin
                  state    <= IDLE;
                  bus_busy <= 1'b0;
               end
            end
            GRANT: begin
               // A still-high request here can only be a CiM at its hold limit.
               if (!owner_req || (!master_gnt && hold_cnt == HOLD_W'(MAX_HOLD))) begin
                  state       <= TURNAROUND;
                  master_gnt  <= 1'b0;
                  cim_gnt     <= '0;
                  bus_busy    <= 1'b0;
                  hold_cnt    <= '0;
                  timeout_err <= owner_req;
               end else if (!master_gnt) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               master_gnt <= 1'b0;
               cim_gnt    <= '0;
               bus_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

   localparam int N  = 64;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          master_req;
   logic [N-1:0]  cim_req;
   logic          clr_stats;
   logic          master_gnt;
   logic [N-1:0]  cim_gnt;
   logic [5:0]    grant_id;
   logic          bus_busy;
   logic          timeout_err;
   logic [CW-1:0] grant_count;

   int errors = 0;
   int checks = 0;

   bus_arbiter #(.NUM_CIMS(N), .MAX_HOLD(8), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .master_req(master_req),
      .cim_req(cim_req), .clr_stats(clr_stats), .master_gnt(master_gnt),
      .cim_gnt(cim_gnt), .grant_id(grant_id), .bus_busy(bus_busy),
      .timeout_err(timeout_err), .grant_count(grant_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] bit_of(input int idx);
      logic [N-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   initial begin
      int exp_idx;
      rst_n = 1'b1; enable = 1'b1; master_req = 1'b0; cim_req = '0; clr_stats = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("rst_master_gnt", master_gnt, 0);
      check("rst_cim_gnt", cim_gnt, 0);
      check("rst_busy", bus_busy, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_count", grant_count, 0);
      check("rst_grant_id", grant_id, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Two CiMs held high from rr_ptr=0: 3, 60, 3 each for 8 cycles with forced release.
      cim_req = bit_of(3) | bit_of(60);
      tick();
      for (int g = 0; g < 3; g++) begin
         exp_idx = (g % 2 == 0) ? 3 : 60;
         check("rr_grant_id", grant_id, exp_idx);
         for (int c = 0; c < 8; c++) begin
            check("rr_hold_gnt", cim_gnt, bit_of(exp_idx));
            check("rr_hold_no_timeout", timeout_err, 0);
            tick();
         end
         check("rr_gap_gnt", cim_gnt, 0);
         check("rr_gap_busy", bus_busy, 0);
         check("rr_timeout_pulse", timeout_err, 1);
         if (g == 2) cim_req = '0;
         tick();
      end
      check("rr_idle_busy", bus_busy, 0);
      check("rr_idle_timeout", timeout_err, 0);
      check("rr_count", grant_count, 3);

      // Master held 20 cycles: no hold limit, grant_id untouched.
      master_req = 1'b1;
      tick();
      for (int c = 0; c < 20; c++) begin
         check("mst_gnt", master_gnt, 1);
         check("mst_no_timeout", timeout_err, 0);
         if (c == 19) master_req = 1'b0;
         tick();
      end
      check("mst_released", master_gnt, 0);
      check("mst_grant_id_kept", grant_id, 3);
      tick();

      // Master and cim[5] together from IDLE: master first, turnaround, then cim 5.
      master_req = 1'b1; cim_req = bit_of(5);
      tick();
      check("pri_master", master_gnt, 1);
      check("pri_cim_low", cim_gnt, 0);
      check("pri_busy", bus_busy, 1);
      master_req = 1'b0;
      tick();
      check("pri_ta_master", master_gnt, 0);
      check("pri_ta_cim", cim_gnt, 0);
      tick();
      check("pri_cim5", cim_gnt, bit_of(5));
      check("pri_id5", grant_id, 5);
      check("pri_master_low", master_gnt, 0);
      master_req = 1'b1;
      tick();
      check("no_preempt_cim5", cim_gnt, bit_of(5));
      check("no_preempt_master", master_gnt, 0);
      master_req = 1'b0; cim_req = '0;
      tick();
      tick();
      check("pri_idle", bus_busy, 0);

      // Bring rr_ptr to 63 via cim 62, then 63 and 0 requested: 63 first, then wrap to 0.
      cim_req = bit_of(62);
      tick();
      check("wrap_62", cim_gnt, bit_of(62));
      cim_req = '0;
      tick();
      tick();
      cim_req = bit_of(63) | bit_of(0);
      tick();
      check("wrap_63_gnt", cim_gnt, bit_of(63));
      check("wrap_63_id", grant_id, 63);
      cim_req = bit_of(0);
      tick();
      check("wrap_ta", cim_gnt, 0);
      tick();
      check("wrap_0_gnt", cim_gnt, bit_of(0));
      check("wrap_0_id", grant_id, 0);
      cim_req = '0;
      tick();
      tick();

      // enable=0 blocks new grants but lets the current one finish.
      enable = 1'b0; master_req = 1'b1; cim_req = bit_of(7);
      tick(); tick(); tick();
      check("dis_no_master", master_gnt, 0);
      check("dis_no_cim", cim_gnt, 0);
      check("dis_idle", bus_busy, 0);
      enable = 1'b1;
      tick();
      check("en_master", master_gnt, 1);
      enable = 1'b0;
      tick();
      check("dis_keep_master", master_gnt, 1);
      master_req = 1'b0;
      tick();
      tick();
      check("dis_to_idle", bus_busy, 0);
      check("dis_cim7_blocked", cim_gnt, 0);

      // Reset in the middle of a CiM grant drops it at once; fresh arbitration afterwards.
      enable = 1'b1;
      tick();
      check("pre_rst_cim7", cim_gnt, bit_of(7));
      #2 rst_n = 1'b0;
      #1;
      check("arst_cim", cim_gnt, 0);
      check("arst_busy", bus_busy, 0);
      check("arst_id", grant_id, 0);
      check("arst_count", grant_count, 0);
      #2 rst_n = 1'b1;
      #1;
      check("post_rst_still_low", cim_gnt, 0);
      tick();
      check("post_rst_cim7", cim_gnt, bit_of(7));
      check("post_rst_count", grant_count, 1);
      cim_req = '0;
      tick();
      tick();

      // Saturation of grant_count and clear-beats-grant.
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("clr_count", grant_count, 0);
      for (int k = 0; k < 255; k++) begin
         master_req = 1'b1;
         tick();
         master_req = 1'b0;
         tick();
      end
      check("sat_reach", grant_count, 8'hFF);
      master_req = 1'b1;
      tick();
      check("sat_extra_gnt", master_gnt, 1);
      check("sat_hold", grant_count, 8'hFF);
      master_req = 1'b0;
      tick();
      master_req = 1'b1; clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("clr_vs_grant_gnt", master_gnt, 1);
      check("clr_vs_grant_count", grant_count, 0);
      master_req = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
